// File: rtl/fib_if.sv
// Signal bundle between the FIB and its neighbours (PIT and network-side data interface).
//   slave  : FIB side    - takes interests, data names, payload and PIT decisions;
//                          drives offers, payload bytes and lookup results.
//   master : neighbour side, the mirror image of slave.
interface fib_if;
    logic [63:0] pit_in_prefix;
    logic [5:0]  pit_in_len;
    logic        fib_out_bit;
    logic        start_send_to_pit;
    logic        rejected;
    logic [63:0] data_in_prefix;
    logic [5:0]  data_in_len;
    logic        data_ready;
    logic [7:0]  data_in;
    logic [63:0] pit_out_prefix;
    logic [5:0]  pit_out_len;
    logic        prefix_ready;
    logic [7:0]  out_data;
    logic [63:0] longest_matching_prefix;
    logic [5:0]  longest_matching_prefix_len;
    logic        ready_for_data;
    logic        clk_out;

    modport slave (
        input  pit_in_prefix, pit_in_len, fib_out_bit, start_send_to_pit, rejected,
               data_in_prefix, data_in_len, data_ready, data_in,
        output pit_out_prefix, pit_out_len, prefix_ready, out_data,
               longest_matching_prefix, longest_matching_prefix_len, ready_for_data, clk_out
    );

    modport master (
        output pit_in_prefix, pit_in_len, fib_out_bit, start_send_to_pit, rejected,
               data_in_prefix, data_in_len, data_ready, data_in,
        input  pit_out_prefix, pit_out_len, prefix_ready, out_data,
               longest_matching_prefix, longest_matching_prefix_len, ready_for_data, clk_out
    );
endinterface

// File: rtl/fib.sv
// Forwarding Information Base: learns prefixes from outgoing interests, reports the
// longest matching route, filters incoming data against the table, offers hits to the
// PIT and streams PAYLOAD_BYTES payload bytes when the PIT accepts.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fib_if.slave (interest/data requests in, PIT offer, payload and results out)
module fib #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned PAYLOAD_BYTES = 8
) (
    input  logic clk,
    input  logic rst,
    fib_if.slave bus
);
    localparam int unsigned NAME_W = 64;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SCAN_W = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W  = $clog2(PAYLOAD_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        OUT_SEARCH = 3'd1,
        IN_SEARCH  = 3'd2,
        WAIT_PIT   = 3'd3,
        STREAM     = 3'd4
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [NAME_W-1:0] prefix;
        logic [LEN_W-1:0]  len;
    } entry_t;

    state_t            state_q, state_d;
    entry_t            tbl_q [DEPTH];
    entry_t            tbl_d [DEPTH];
    logic [NAME_W-1:0] key_prefix_q, key_prefix_d;
    logic [LEN_W-1:0]  key_len_q, key_len_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic              found_q, found_d;
    logic [NAME_W-1:0] best_prefix_q, best_prefix_d;
    logic [LEN_W-1:0]  best_len_q, best_len_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;

    logic [NAME_W-1:0] pit_out_prefix_q, pit_out_prefix_d;
    logic [LEN_W-1:0]  pit_out_len_q, pit_out_len_d;
    logic              prefix_ready_q, prefix_ready_d;
    logic [BYTE_W-1:0] out_data_q, out_data_d;
    logic [NAME_W-1:0] lmp_q, lmp_d;
    logic [LEN_W-1:0]  lmp_len_q, lmp_len_d;
    logic              ready_q, ready_d;
    logic              clk_out_q, clk_out_d;

    entry_t            cur_c;
    logic [NAME_W-1:0] mask_c;
    logic              hit_c;
    logic              free_found_c;
    logic [IDX_W-1:0]  free_idx_c;
    logic [IDX_W-1:0]  wr_idx_c;

    // Entry under the scan pointer matched against the latched name; mask keeps the top len bits.
    always_comb begin
        cur_c  = tbl_q[IDX_W'(scan_q)];
        mask_c = ~({NAME_W{1'b1}} >> cur_c.len);
        hit_c  = cur_c.valid && (cur_c.len <= key_len_q) &&
                 (((cur_c.prefix ^ key_prefix_q) & mask_c) == '0);
    end

    // Insertion slot: lowest invalid entry, else the round-robin victim.
    always_comb begin
        free_found_c = 1'b0;
        free_idx_c   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!tbl_q[i].valid) begin
                free_found_c = 1'b1;
                free_idx_c   = IDX_W'(i);
            end
        end
        wr_idx_c = free_found_c ? free_idx_c : rr_q;
    end

    // Next-state and output logic.
    always_comb begin
        state_d          = state_q;
        tbl_d            = tbl_q;
        key_prefix_d     = key_prefix_q;
        key_len_d        = key_len_q;
        scan_d           = scan_q;
        found_d          = found_q;
        best_prefix_d    = best_prefix_q;
        best_len_d       = best_len_q;
        rr_d             = rr_q;
        byte_cnt_d       = byte_cnt_q;
        pit_out_prefix_d = pit_out_prefix_q;
        pit_out_len_d    = pit_out_len_q;
        prefix_ready_d   = prefix_ready_q;
        out_data_d       = out_data_q;
        lmp_d            = lmp_q;
        lmp_len_d        = lmp_len_q;
        clk_out_d        = 1'b0;

        case (state_q)
            IDLE: begin
                scan_d        = '0;
                found_d       = 1'b0;
                best_prefix_d = '0;
                best_len_d    = '0;
                if (bus.fib_out_bit) begin
                    key_prefix_d = bus.pit_in_prefix;
                    key_len_d    = bus.pit_in_len;
                    state_d      = OUT_SEARCH;
                end else if (bus.data_ready) begin
                    key_prefix_d = bus.data_in_prefix;
                    key_len_d    = bus.data_in_len;
                    state_d      = IN_SEARCH;
                end
            end

            OUT_SEARCH, IN_SEARCH: begin
                if (scan_q != SCAN_W'(DEPTH)) begin
                    // Strictly longer wins, so on equal length the lower index is kept.
                    if (hit_c && (!found_q || (cur_c.len > best_len_q))) begin
                        found_d       = 1'b1;
                        best_prefix_d = cur_c.prefix;
                        best_len_d    = cur_c.len;
                    end
                    scan_d = scan_q + SCAN_W'(1);
                end else if (state_q == OUT_SEARCH) begin
                    state_d = IDLE;
                    if (found_q) begin
                        lmp_d     = best_prefix_q;
                        lmp_len_d = best_len_q;
                    end else begin
                        tbl_d[wr_idx_c].valid  = 1'b1;
                        tbl_d[wr_idx_c].prefix = key_prefix_q;
                        tbl_d[wr_idx_c].len    = key_len_q;
                        lmp_d                  = key_prefix_q;
                        lmp_len_d              = key_len_q;
                        if (!free_found_c) begin
                            rr_d = rr_q + IDX_W'(1);
                        end
                    end
                end else begin
                    if (found_q) begin
                        pit_out_prefix_d = key_prefix_q;
                        pit_out_len_d    = key_len_q;
                        prefix_ready_d   = 1'b1;
                        state_d          = WAIT_PIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            WAIT_PIT: begin
                if (bus.rejected) begin
                    prefix_ready_d = 1'b0;
                    state_d        = IDLE;
                end else if (bus.start_send_to_pit) begin
                    // First payload byte is captured on the accept edge itself.
                    prefix_ready_d = 1'b0;
                    out_data_d     = bus.data_in;
                    clk_out_d      = 1'b1;
                    byte_cnt_d     = CNT_W'(1);
                    state_d        = STREAM;
                end
            end

            STREAM: begin
                if (byte_cnt_q == CNT_W'(PAYLOAD_BYTES)) begin
                    state_d = IDLE;
                end else begin
                    out_data_d = bus.data_in;
                    clk_out_d  = 1'b1;
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl_q[i] <= '0;
            end
            key_prefix_q     <= '0;
            key_len_q        <= '0;
            scan_q           <= '0;
            found_q          <= 1'b0;
            best_prefix_q    <= '0;
            best_len_q       <= '0;
            rr_q             <= '0;
            byte_cnt_q       <= '0;
            pit_out_prefix_q <= '0;
            pit_out_len_q    <= '0;
            prefix_ready_q   <= 1'b0;
            out_data_q       <= '0;
            lmp_q            <= '0;
            lmp_len_q        <= '0;
            ready_q          <= 1'b1;
            clk_out_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            tbl_q            <= tbl_d;
            key_prefix_q     <= key_prefix_d;
            key_len_q        <= key_len_d;
            scan_q           <= scan_d;
            found_q          <= found_d;
            best_prefix_q    <= best_prefix_d;
            best_len_q       <= best_len_d;
            rr_q             <= rr_d;
            byte_cnt_q       <= byte_cnt_d;
            pit_out_prefix_q <= pit_out_prefix_d;
            pit_out_len_q    <= pit_out_len_d;
            prefix_ready_q   <= prefix_ready_d;
            out_data_q       <= out_data_d;
            lmp_q            <= lmp_d;
            lmp_len_q        <= lmp_len_d;
            ready_q          <= ready_d;
            clk_out_q        <= clk_out_d;
        end
    end

    assign bus.pit_out_prefix              = pit_out_prefix_q;
    assign bus.pit_out_len                 = pit_out_len_q;
    assign bus.prefix_ready                = prefix_ready_q;
    assign bus.out_data                    = out_data_q;
    assign bus.longest_matching_prefix     = lmp_q;
    assign bus.longest_matching_prefix_len = lmp_len_q;
    assign bus.ready_for_data              = ready_q;
    assign bus.clk_out                     = clk_out_q;
endmodule

// File: tb/tb_fib.sv
// Scoreboard bench for fib: drivers push expected results from a table model,
// a negedge monitor pops and compares whenever the FIB presents an output.
module tb_fib;
    localparam int unsigned DEPTH         = 8;
    localparam int unsigned PAYLOAD_BYTES = 8;
    localparam int          TIMEOUT       = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fib_if bif ();

    fib #(.DEPTH(DEPTH), .PAYLOAD_BYTES(PAYLOAD_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct { bit is_lookup; logic [63:0] pfx; logic [5:0] len; } done_t;
    typedef struct { logic [63:0] pfx; logic [5:0] len; } offer_t;

    done_t      done_q [$];
    offer_t     offer_q[$];
    logic [7:0] byte_q [$];
    done_t      mon_d;
    offer_t     mon_o;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference table model ----------------
    bit          m_valid [DEPTH];
    logic [63:0] m_prefix[DEPTH];
    logic [5:0]  m_len   [DEPTH];
    int          m_rr;

    function automatic void m_clear();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_valid[i] = 1'b0; m_prefix[i] = '0; m_len[i] = '0;
        end
        m_rr = 0;
    endfunction

    function automatic bit m_hit(input int i, input logic [63:0] name, input logic [5:0] len);
        int sh;
        if (!m_valid[i] || m_len[i] > len) return 1'b0;
        if (m_len[i] == 6'd0) return 1'b1;
        sh = 64 - int'(m_len[i]);
        return (m_prefix[i] >> sh) == (name >> sh);
    endfunction

    function automatic int m_lookup(input logic [63:0] name, input logic [5:0] len);
        int best = -1;
        for (int i = 0; i < int'(DEPTH); i++)
            if (m_hit(i, name, len) && (best < 0 || m_len[i] > m_len[best])) best = i;
        return best;
    endfunction

    function automatic void m_insert(input logic [63:0] name, input logic [5:0] len);
        int slot = -1;
        for (int i = 0; i < int'(DEPTH); i++)
            if (!m_valid[i] && slot < 0) slot = i;
        if (slot < 0) begin
            slot = m_rr;
            m_rr = (m_rr + 1) % int'(DEPTH);
        end
        m_valid[slot] = 1'b1; m_prefix[slot] = name; m_len[slot] = len;
    endfunction

    function automatic void interest_expect(input logic [63:0] name, input logic [5:0] len);
        done_t d;
        int idx = m_lookup(name, len);
        d.is_lookup = 1'b1;
        if (idx >= 0) begin
            d.pfx = m_prefix[idx]; d.len = m_len[idx];
        end else begin
            m_insert(name, len);
            d.pfx = name; d.len = len;
        end
        done_q.push_back(d);
    endfunction

    // decision: 0 reject, 1 accept, 2 reject with start also high
    function automatic bit data_expect(input logic [63:0] name, input logic [5:0] len,
                                       input int decision, input logic [7:0] b0);
        done_t  d;
        offer_t o;
        bit hit = (m_lookup(name, len) >= 0);
        if (hit) begin
            o.pfx = name; o.len = len;
            offer_q.push_back(o);
            if (decision == 1)
                for (int k = 0; k < int'(PAYLOAD_BYTES); k++) byte_q.push_back(b0 + 8'(k));
        end
        d.is_lookup = 1'b0; d.pfx = '0; d.len = '0;
        done_q.push_back(d);
        return hit;
    endfunction

    // ---------------- monitor ----------------
    logic pr_prev  = 1'b0;
    logic rdy_prev = 1'b1;
    always @(negedge clk) begin
        if (!rst) begin
            if (bif.clk_out === 1'b1) begin
                if (byte_q.size() == 0) chk("unexpected clk_out", 64'(bif.clk_out), 64'd0);
                else chk("stream byte", 64'(bif.out_data), 64'(byte_q.pop_front()));
            end
            if (bif.prefix_ready === 1'b1 && pr_prev !== 1'b1) begin
                if (offer_q.size() == 0) chk("unexpected offer", 64'(bif.prefix_ready), 64'd0);
                else begin
                    mon_o = offer_q.pop_front();
                    chk("offer prefix", bif.pit_out_prefix, mon_o.pfx);
                    chk("offer len", 64'(bif.pit_out_len), 64'(mon_o.len));
                end
            end
            if (bif.ready_for_data === 1'b1 && rdy_prev !== 1'b1) begin
                if (done_q.size() == 0) chk("unexpected idle return", 64'(bif.ready_for_data), 64'd0);
                else begin
                    mon_d = done_q.pop_front();
                    if (mon_d.is_lookup) begin
                        chk("lookup prefix", bif.longest_matching_prefix, mon_d.pfx);
                        chk("lookup len", 64'(bif.longest_matching_prefix_len), 64'(mon_d.len));
                    end
                    chk("offer low at idle", 64'(bif.prefix_ready), 64'd0);
                end
            end
        end
        pr_prev  = bif.prefix_ready;
        rdy_prev = bif.ready_for_data;
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name, input int exp_cycles);
        int n = 0;
        while (bif.ready_for_data !== 1'b1 && n < TIMEOUT) begin
            tick();
            n++;
        end
        chk(name, 64'(n), 64'(exp_cycles));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif.fib_out_bit = 1'b0; bif.data_ready = 1'b0;
        bif.start_send_to_pit = 1'b0; bif.rejected = 1'b0;
        tick();
        done_q.delete(); offer_q.delete(); byte_q.delete();
        m_clear();
        chk("reset prefix_ready", 64'(bif.prefix_ready), 64'd0);
        chk("reset clk_out", 64'(bif.clk_out), 64'd0);
        chk("reset out_data", 64'(bif.out_data), 64'd0);
        chk("reset pit_out_prefix", bif.pit_out_prefix, 64'd0);
        chk("reset pit_out_len", 64'(bif.pit_out_len), 64'd0);
        chk("reset lmp", bif.longest_matching_prefix, 64'd0);
        chk("reset lmp_len", 64'(bif.longest_matching_prefix_len), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("ready after reset release", 64'(bif.ready_for_data), 64'd1);
    endtask

    task automatic interest(input logic [63:0] name, input logic [5:0] len);
        interest_expect(name, len);
        bif.pit_in_prefix = name; bif.pit_in_len = len; bif.fib_out_bit = 1'b1;
        tick();
        bif.fib_out_bit = 1'b0;
        chk("ready low after interest accept", 64'(bif.ready_for_data), 64'd0);
        wait_ready("interest search latency", int'(DEPTH) + 1);
    endtask

    // Called just after the edge that accepted a data request.
    task automatic data_finish(input bit hit, input int decision, input logic [7:0] b0, input int abort_at);
        int n = 0;
        chk("ready low after data accept", 64'(bif.ready_for_data), 64'd0);
        if (!hit) begin
            wait_ready("data miss latency", int'(DEPTH) + 1);
            return;
        end
        while (bif.prefix_ready !== 1'b1 && n < TIMEOUT) begin
            tick();
            n++;
        end
        chk("offer latency", 64'(n), 64'(int'(DEPTH) + 1));
        repeat ($urandom_range(0, 3)) begin
            tick();
            chk("offer held", 64'(bif.prefix_ready), 64'd1);
        end
        if (decision != 1) begin
            bif.rejected = 1'b1; bif.start_send_to_pit = (decision == 2);
            tick();
            bif.rejected = 1'b0; bif.start_send_to_pit = 1'b0;
            chk("offer cleared on reject", 64'(bif.prefix_ready), 64'd0);
            chk("idle after reject", 64'(bif.ready_for_data), 64'd1);
            chk("no stream on reject", 64'(bif.clk_out), 64'd0);
        end else begin
            bif.start_send_to_pit = 1'b1; bif.data_in = b0;
            tick();
            bif.start_send_to_pit = 1'b0;
            chk("offer cleared on accept", 64'(bif.prefix_ready), 64'd0);
            for (int k = 1; k < int'(PAYLOAD_BYTES); k++) begin
                if (abort_at != 0 && k == abort_at) begin
                    do_reset();
                    return;
                end
                bif.data_in = b0 + 8'(k);
                tick();
            end
            tick();
            chk("idle after stream", 64'(bif.ready_for_data), 64'd1);
        end
    endtask

    task automatic data_pkt(input logic [63:0] name, input logic [5:0] len, input int decision,
                            input logic [7:0] b0, input int abort_at);
        bit hit = data_expect(name, len, decision, b0);
        bif.data_in_prefix = name; bif.data_in_len = len; bif.data_ready = 1'b1;
        tick();
        bif.data_ready = 1'b0;
        data_finish(hit, decision, b0, abort_at);
    endtask

    // Both requests together: the interest goes first, the still-held data request follows.
    task automatic both_req(input logic [63:0] iname, input logic [5:0] ilen,
                            input logic [63:0] dname, input logic [5:0] dlen, input logic [7:0] b0);
        bit hit;
        interest_expect(iname, ilen);
        hit = data_expect(dname, dlen, 1, b0);
        bif.pit_in_prefix = iname; bif.pit_in_len = ilen; bif.fib_out_bit = 1'b1;
        bif.data_in_prefix = dname; bif.data_in_len = dlen; bif.data_ready = 1'b1;
        tick();
        bif.fib_out_bit = 1'b0;
        chk("ready low after both accept", 64'(bif.ready_for_data), 64'd0);
        wait_ready("priority interest latency", int'(DEPTH) + 1);
        tick();
        bif.data_ready = 1'b0;
        data_finish(hit, 1, b0, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [63:0] nm;
        logic [63:0] base [6];
        logic [5:0]  ln;
        int          op;

        bif.pit_in_prefix = '0; bif.pit_in_len = '0; bif.fib_out_bit = 1'b0;
        bif.start_send_to_pit = 1'b0; bif.rejected = 1'b0;
        bif.data_in_prefix = '0; bif.data_in_len = '0; bif.data_ready = 1'b0; bif.data_in = '0;
        m_clear();
        tick();
        do_reset();

        // empty table: insertion, rejected, accepted, miss, table unchanged
        interest(64'h0000FFFF0000FFFF, 6'd10);
        data_pkt(64'h0000FFFF0000FFFF, 6'd10, 2, 8'h00, 0);
        data_pkt(64'h0000FFFF0000FFFF, 6'd10, 1, 8'h01, 0);
        data_pkt(64'h8000000000000000, 6'd10, 1, 8'h00, 0);
        interest(64'h0000FFFF0000FFFF, 6'd10);

        // longest match, len 63 ignores bit 0, len 0 matches all
        do_reset();
        interest(64'h0000FFFF0000FFFF, 6'd10);
        interest(64'h0000000000000000, 6'd4);
        interest(64'h003F000000000000, 6'd20);
        interest(64'h8000000000000000, 6'd20);
        interest(64'hA5A5A5A5A5A5A5A4, 6'd63);
        data_pkt(64'hA5A5A5A5A5A5A5A5, 6'd63, 1, 8'h80, 0);
        data_pkt(64'hA5A5A5A5A5A5A5A6, 6'd63, 0, 8'h00, 0);
        interest(64'hDEADBEEF00000000, 6'd0);
        data_pkt(64'h123456789ABCDEF0, 6'd2, 0, 8'h00, 0);
        both_req(64'hC000000000000000, 6'd3, 64'hC100000000000000, 6'd9, 8'hF0);

        // table full: round-robin replacement of entries 0 and 1
        do_reset();
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            nm = (64'(i + 1) << 56) | 64'h0000123400005678;
            interest(nm, 6'd8);
        end
        data_pkt(64'h01FF000000000000, 6'd8, 0, 8'h00, 0);
        data_pkt(64'h02FF000000000000, 6'd8, 0, 8'h00, 0);
        data_pkt(64'h03FF000000000000, 6'd8, 0, 8'h00, 0);
        data_pkt(64'h0AFF000000000000, 6'd8, 1, 8'h20, 0);
        interest(64'h0B00000000000000, 6'd8);
        data_pkt(64'h0B00000000000000, 6'd8, 0, 8'h00, 0);
        data_pkt(64'h03FF000000000000, 6'd8, 0, 8'h00, 0);
        // reset in the middle of a stream clears the table
        data_pkt(64'h04AA000000000000, 6'd12, 1, 8'h50, 3);
        data_pkt(64'h04AA000000000000, 6'd12, 1, 8'h00, 0);

        // randomized traffic against the model
        for (int b = 0; b < 6; b++) base[b] = {$urandom(), $urandom()};
        for (int t = 0; t < 70; t++) begin
            op = int'($urandom_range(0, 9));
            nm = base[$urandom_range(0, 5)] ^ ({$urandom(), $urandom()} >> $urandom_range(6, 63));
            ln = 6'($urandom_range(0, 40));
            if (op < 4)
                interest(nm, ln);
            else if (op < 9)
                data_pkt(nm, ln, int'($urandom_range(0, 2)), 8'($urandom()), 0);
            else
                both_req(nm, ln, base[$urandom_range(0, 5)], 6'($urandom_range(0, 20)), 8'($urandom()));
        end

        repeat (4) tick();
        chk("pending stream bytes", 64'(byte_q.size()), 64'd0);
        chk("pending offers", 64'(offer_q.size()), 64'd0);
        chk("pending idle returns", 64'(done_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
